// File: rtl/hdmi_pkg.sv
// Shared constants and types for the HDMI period scheduler.
// Holds the TMDS encoder mode codes, the preamble control patterns, the
// period lengths, and the island FSM state type.
package hdmi_pkg;

   localparam logic [2:0] MODE_CONTROL      = 3'd0;
   localparam logic [2:0] MODE_VIDEO        = 3'd1;
   localparam logic [2:0] MODE_VIDEO_GUARD  = 3'd2;
   localparam logic [2:0] MODE_ISLAND       = 3'd3;
   localparam logic [2:0] MODE_ISLAND_GUARD = 3'd4;

   localparam logic [3:0] CTL_VIDEO_PREAMBLE  = 4'b0001;
   localparam logic [3:0] CTL_ISLAND_PREAMBLE = 4'b0101;

   localparam int unsigned PREAMBLE_LEN = 8;
   localparam int unsigned GUARD_LEN    = 2;
   localparam int unsigned PACKET_LEN   = 32;
   localparam int unsigned MIN_CONTROL  = 12;

   typedef enum logic [2:0] {
      StIdle,
      StPreamble,
      StLeadGuard,
      StPacket,
      StTrailGuard
   } island_state_e;

endpackage

// File: rtl/hdmi_raster_counter.sv
// Raster position counter with sync decode.
// Ports:
//   clk_i, rst_ni      pixel clock, async active-low reset
//   px_o, py_o         current position (px wraps at H_TOTAL-1, py at V_TOTAL-1)
//   hsync_o, vsync_o   sync levels decoded from the current position
//   next_active_o      the following line (wrapped) carries active video
module hdmi_raster_counter #(
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned H_FRONT    = 16,
   parameter int unsigned H_SYNC     = 96,
   parameter int unsigned H_TOTAL    = 800,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned V_FRONT    = 10,
   parameter int unsigned V_SYNC     = 2,
   parameter int unsigned V_TOTAL    = 525,
   parameter logic        H_POL      = 1'b0,
   parameter logic        V_POL      = 1'b0,
   parameter int unsigned BIT_WIDTH  = 10,
   parameter int unsigned BIT_HEIGHT = 10
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   output logic [BIT_WIDTH-1:0]  px_o,
   output logic [BIT_HEIGHT-1:0] py_o,
   output logic                  hsync_o,
   output logic                  vsync_o,
   output logic                  next_active_o
);

   localparam int unsigned HSyncStart = H_ACTIVE + H_FRONT;
   localparam int unsigned VSyncStart = V_ACTIVE + V_FRONT;

   logic [BIT_WIDTH-1:0]  px_q, px_d;
   logic [BIT_HEIGHT-1:0] py_q, py_d;

   always_comb begin
      px_d = px_q + BIT_WIDTH'(1);
      py_d = py_q;
      if (32'(px_q) == H_TOTAL - 1) begin
         px_d = '0;
         py_d = (32'(py_q) == V_TOTAL - 1) ? '0 : py_q + BIT_HEIGHT'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         px_q <= '0;
         py_q <= '0;
      end else begin
         px_q <= px_d;
         py_q <= py_d;
      end
   end

   assign px_o    = px_q;
   assign py_o    = py_q;
   assign hsync_o = (32'(px_q) >= HSyncStart && 32'(px_q) < HSyncStart + H_SYNC) ? H_POL : ~H_POL;
   assign vsync_o = (32'(py_q) >= VSyncStart && 32'(py_q) < VSyncStart + V_SYNC) ? V_POL : ~V_POL;
   // Last line wraps to line 0, which is always active.
   assign next_active_o = (32'(py_q) == V_TOTAL - 1) || (32'(py_q) + 1 < V_ACTIVE);

endmodule

// File: rtl/hdmi_period_scheduler.sv
// HDMI period scheduler: sequences control, video preamble/guard/data and
// data-island preamble/guard/packet periods for three TMDS encoders.
// Ports:
//   clk_pixel, reset_n   pixel clock, async active-low reset
//   mode                 encoder mode (control/video/video guard/island/island guard)
//   control_data         {CTL3,CTL2,CTL1,CTL0,vsync,hsync}
//   island_data          TERC4 nibbles {ch2,ch1,ch0}, valid in island mode
//   cx, cy               position the other outputs belong to
//   video_active         high in video mode
//   packet_pending       upstream packet available
//   packet_start         first payload cycle of each packet
//   packet_pixel         payload cycle index 0..31
//   island_payload       payload for the presented packet_pixel (used combinationally)
module hdmi_period_scheduler
   import hdmi_pkg::*;
#(
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned H_FRONT       = 16,
   parameter int unsigned H_SYNC        = 96,
   parameter int unsigned H_TOTAL       = 800,
   parameter int unsigned V_ACTIVE      = 480,
   parameter int unsigned V_FRONT       = 10,
   parameter int unsigned V_SYNC        = 2,
   parameter int unsigned V_TOTAL       = 525,
   parameter logic        H_POL         = 1'b0,
   parameter logic        V_POL         = 1'b0,
   parameter int unsigned ISLAND_OFFSET = 4,
   parameter int unsigned MAX_PACKETS   = 2,
   parameter int unsigned BIT_WIDTH     = 10,
   parameter int unsigned BIT_HEIGHT    = 10
) (
   input  logic                  clk_pixel,
   input  logic                  reset_n,
   output logic [2:0]            mode,
   output logic [5:0]            control_data,
   output logic [11:0]           island_data,
   output logic [BIT_WIDTH-1:0]  cx,
   output logic [BIT_HEIGHT-1:0] cy,
   output logic                  video_active,
   input  logic                  packet_pending,
   output logic                  packet_start,
   output logic [4:0]            packet_pixel,
   input  logic [11:0]           island_payload
);

   localparam int unsigned IslandStart   = H_ACTIVE + ISLAND_OFFSET;
   // Last px an island may occupy while leaving the minimum control period.
   localparam int unsigned IslandLimit   = H_TOTAL - 1 - MIN_CONTROL;
   localparam int unsigned FirstEnd      = IslandStart + PREAMBLE_LEN + 2 * GUARD_LEN
                                           + PACKET_LEN - 1;
   localparam int unsigned VidPreStart   = H_TOTAL - PREAMBLE_LEN - GUARD_LEN;
   localparam int unsigned VidGuardStart = H_TOTAL - GUARD_LEN;

   logic [BIT_WIDTH-1:0]  px;
   logic [BIT_HEIGHT-1:0] py;
   logic                  hsync, vsync, next_active;

   hdmi_raster_counter #(
      .H_ACTIVE  (H_ACTIVE),
      .H_FRONT   (H_FRONT),
      .H_SYNC    (H_SYNC),
      .H_TOTAL   (H_TOTAL),
      .V_ACTIVE  (V_ACTIVE),
      .V_FRONT   (V_FRONT),
      .V_SYNC    (V_SYNC),
      .V_TOTAL   (V_TOTAL),
      .H_POL     (H_POL),
      .V_POL     (V_POL),
      .BIT_WIDTH (BIT_WIDTH),
      .BIT_HEIGHT(BIT_HEIGHT)
   ) u_raster (
      .clk_i        (clk_pixel),
      .rst_ni       (reset_n),
      .px_o         (px),
      .py_o         (py),
      .hsync_o      (hsync),
      .vsync_o      (vsync),
      .next_active_o(next_active)
   );

   island_state_e st_q, st_d, st_cur;
   logic [4:0]    cnt_q, cnt_d, cnt_cur;
   logic [4:0]    npkt_q, npkt_d;

   logic [2:0]    mode_q, mode_d;
   logic [3:0]    ctl_q, ctl_d;
   logic          hsync_q, vsync_q, vact_q, vact_d, pstart_q, pstart_d;
   logic [4:0]    ppix_q, ppix_d;
   logic [BIT_WIDTH-1:0]  cx_q;
   logic [BIT_HEIGHT-1:0] cy_q;

   logic vid, vid_pre, vid_guard, isl_go, isl_more;

   assign vid       = (32'(px) < H_ACTIVE) && (32'(py) < V_ACTIVE);
   assign vid_pre   = next_active && (32'(px) >= VidPreStart) && (32'(px) < VidGuardStart);
   assign vid_guard = next_active && (32'(px) >= VidGuardStart);

   assign isl_go   = (32'(px) == IslandStart) && packet_pending && (FirstEnd <= IslandLimit);
   // Another packet would end its trailing guard at px + PACKET_LEN + GUARD_LEN.
   assign isl_more = packet_pending && (32'(npkt_q) < MAX_PACKETS)
                     && (32'(px) + PACKET_LEN + GUARD_LEN <= IslandLimit);

   always_comb begin
      // The start decision takes effect on the same position it is made at.
      st_cur  = st_q;
      cnt_cur = cnt_q;
      if (st_q == StIdle && isl_go) begin
         st_cur  = StPreamble;
         cnt_cur = '0;
      end

      st_d   = st_cur;
      cnt_d  = cnt_cur + 5'd1;
      npkt_d = npkt_q;
      unique case (st_cur)
         StPreamble: begin
            if (32'(cnt_cur) == PREAMBLE_LEN - 1) begin
               st_d  = StLeadGuard;
               cnt_d = '0;
            end
         end
         StLeadGuard: begin
            if (32'(cnt_cur) == GUARD_LEN - 1) begin
               st_d   = StPacket;
               cnt_d  = '0;
               npkt_d = 5'd1;
            end
         end
         StPacket: begin
            if (32'(cnt_cur) == PACKET_LEN - 1) begin
               cnt_d = '0;
               if (isl_more) npkt_d = npkt_q + 5'd1;
               else          st_d   = StTrailGuard;
            end
         end
         StTrailGuard: begin
            if (32'(cnt_cur) == GUARD_LEN - 1) begin
               st_d  = StIdle;
               cnt_d = '0;
            end
         end
         default: begin
            st_d  = StIdle;
            cnt_d = '0;
         end
      endcase

      mode_d   = MODE_CONTROL;
      ctl_d    = '0;
      pstart_d = 1'b0;
      ppix_d   = '0;
      vact_d   = vid;
      if (vid) begin
         mode_d = MODE_VIDEO;
      end else if (vid_pre) begin
         ctl_d = CTL_VIDEO_PREAMBLE;
      end else if (vid_guard) begin
         mode_d = MODE_VIDEO_GUARD;
      end else begin
         unique case (st_cur)
            StPreamble:               ctl_d  = CTL_ISLAND_PREAMBLE;
            StLeadGuard, StTrailGuard: mode_d = MODE_ISLAND_GUARD;
            StPacket: begin
               mode_d   = MODE_ISLAND;
               pstart_d = (cnt_cur == '0);
               ppix_d   = cnt_cur;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_pixel or negedge reset_n) begin
      if (!reset_n) begin
         st_q     <= StIdle;
         cnt_q    <= '0;
         npkt_q   <= '0;
         mode_q   <= MODE_CONTROL;
         ctl_q    <= '0;
         hsync_q  <= ~H_POL;
         vsync_q  <= ~V_POL;
         vact_q   <= 1'b0;
         pstart_q <= 1'b0;
         ppix_q   <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
      end else begin
         st_q     <= st_d;
         cnt_q    <= cnt_d;
         npkt_q   <= npkt_d;
         mode_q   <= mode_d;
         ctl_q    <= ctl_d;
         hsync_q  <= hsync;
         vsync_q  <= vsync;
         vact_q   <= vact_d;
         pstart_q <= pstart_d;
         ppix_q   <= ppix_d;
         cx_q     <= px;
         cy_q     <= py;
      end
   end

   logic unused_payload;
   assign unused_payload = ^{island_payload[3], island_payload[1:0]};

   assign mode         = mode_q;
   assign control_data = {ctl_q, vsync_q, hsync_q};
   assign cx           = cx_q;
   assign cy           = cy_q;
   assign video_active = vact_q;
   assign packet_start = pstart_q;
   assign packet_pixel = ppix_q;
   // Payload arrives in the cycle its packet_pixel is presented, so it bypasses the registers.
   assign island_data  = (mode_q == MODE_ISLAND) ?
                         {island_payload[11:8], island_payload[7:4], ppix_q != 5'd0,
                          island_payload[2], vsync_q, hsync_q} : 12'd0;

   video_island_overlap: assert property (@(posedge clk_pixel) disable iff (!reset_n)
      !((vid || vid_pre || vid_guard) && st_cur != StIdle));

endmodule
